gb_cpu_interrupt_ctrl: RTL

GB_CPU_INTERRUPT_CTRL -- requirements
Module: gb_cpu_interrupt_ctrl

---
 rtl/gb_cpu_interrupt_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy style interrupt controller: IF/IE registers, IME with delayed EI,
// and a two-state dispatch FSM that latches the winning vector until ack.
module gb_cpu_interrupt_ctrl #(
    parameter int             NUM_SOURCES   = 5,
    parameter logic [7:0]     VECTOR_BASE   = 8'h40,
    parameter logic [7:0]     VECTOR_STRIDE = 8'h08,
    parameter int             EI_DELAY      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_i,
    input  logic                   if_wr_en,
    input  logic [7:0]             if_wr_data,
    input  logic                   ie_wr_en,
    input  logic [7:0]             ie_wr_data,
    input  logic                   enable_interrupts,
    input  logic                   disable_interrupts,
    input  logic                   reti,
    input  logic                   dispatch_start,
    input  logic                   dispatch_ack,
    output logic [7:0]             reg_IF,
    output logic [7:0]             reg_IE,
    output logic                   IME,
    output logic                   interrupt_queued,
    output logic                   wake,
    output logic [7:0]             interrupt_vector,
    output logic                   dispatch_busy
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_SOURCES-1:0] r_if;
    logic [7:0]             r_ie;
    logic                   r_ime;
    logic                   r_ei_active;
    logic [1:0]             r_ei_cnt;
    logic [2:0]             r_idx;
    logic                   r_idx_valid;
    logic [7:0]             r_vec;

    logic [NUM_SOURCES-1:0] w_pending;
    logic [NUM_SOURCES-1:0] w_ack_clear;
    logic [NUM_SOURCES-1:0] w_if_base;
    logic                   w_found;
    logic [2:0]             w_idx;
    logic [7:0]             w_vec_calc;
    logic                   w_start_accept;
    logic                   w_ack_accept;
    logic                   w_di;
    logic                   w_reti;
    logic                   w_unused;

    assign w_unused  = ^if_wr_data;
    assign w_pending = r_if & r_ie[NUM_SOURCES-1:0];

    // Lowest index wins, so scan downward and let the last hit stick.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_found = 1'b1;
                w_idx   = 3'(i);
            end
        end
    end

    assign w_vec_calc     = VECTOR_BASE + 8'(w_idx) * VECTOR_STRIDE;
    assign w_start_accept = dispatch_start && (r_state == ST_IDLE);
    assign w_ack_accept   = dispatch_ack && (r_state == ST_DISPATCH);

    // EI together with DI behaves as RETI; a lone DI beats RETI.
    assign w_di   = disable_interrupts && !enable_interrupts;
    assign w_reti = reti || (enable_interrupts && disable_interrupts);

    always_comb begin
        w_ack_clear = '0;
        if (w_ack_accept && r_idx_valid) begin
            w_ack_clear[r_idx] = 1'b1;
        end
    end

    assign w_if_base = if_wr_en ? if_wr_data[NUM_SOURCES-1:0] : r_if;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (dispatch_start) w_state_next = ST_DISPATCH;
            ST_DISPATCH: if (dispatch_ack)   w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_if        <= '0;
            r_ie        <= 8'h00;
            r_ime       <= 1'b0;
            r_ei_active <= 1'b0;
            r_ei_cnt    <= 2'd0;
            r_idx       <= 3'd0;
            r_idx_valid <= 1'b0;
            r_vec       <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_if    <= (w_if_base & ~w_ack_clear) | irq_i;
            if (ie_wr_en) begin
                r_ie <= ie_wr_data;
            end

            if (w_start_accept) begin
                r_idx       <= w_idx;
                r_idx_valid <= w_found;
                r_vec       <= w_found ? w_vec_calc : 8'h00;
            end

            if (w_start_accept || w_di) begin
                r_ime       <= 1'b0;
                r_ei_active <= 1'b0;
            end else if (w_reti) begin
                r_ime       <= 1'b1;
                r_ei_active <= 1'b0;
            end else if (enable_interrupts && !r_ime) begin
                if (EI_DELAY == 0) begin
                    r_ime       <= 1'b1;
                    r_ei_active <= 1'b0;
                end else begin
                    r_ei_active <= 1'b1;
                    r_ei_cnt    <= 2'(EI_DELAY);
                end
            end else if (r_ei_active) begin
                if (r_ei_cnt <= 2'd1) begin
                    r_ime       <= 1'b1;
                    r_ei_active <= 1'b0;
                end else begin
                    r_ei_cnt <= r_ei_cnt - 2'd1;
                end
            end
        end
    end

    always_comb begin
        reg_IF                  = 8'hFF;
        reg_IF[NUM_SOURCES-1:0] = r_if;
    end

    assign reg_IE           = r_ie;
    assign IME              = r_ime;
    assign wake             = |w_pending;
    assign interrupt_queued = r_ime && (|w_pending);
    assign dispatch_busy    = (r_state == ST_DISPATCH);
    assign interrupt_vector = dispatch_busy ? r_vec : 8'h00;

endmodule
